conv_sched: RTL and testbench

//  Sequences the conv datapath for one layer as configured over AXI-Lite. Takes the command word
//  (state/layer/ic/oc/valid) and the 80-bit bias+weight pulses, and buffers params in a FIFO.

---
 rtl/conv_sched_pkg.sv | 33 +++
 rtl/conv_sched_param_fifo.sv | 64 ++++++
 rtl/conv_sched.sv | 236 +++++++++++++++++++++++
 tb/tb_conv_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared definitions for the conv layer scheduler.
// Contents: the FSM state enum, command codes carried in the command word,
// the bit positions of the bias and weights in a parameter word, the error bit indices,
// and a helper that turns a channel count into its last index.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_RUN,
    ST_NEXT,
    ST_DONE
  } sched_state_e;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_ABORT = 2'd2;

  localparam int BIAS_MSB = 79;
  localparam int BIAS_LSB = 72;
  localparam int WGT_W    = 72;

  localparam int ERR_OVF  = 0;
  localparam int ERR_BUSY = 1;

  // Last index for a channel count. A zero count never runs a pass,
  // so it maps to 0 instead of wrapping to 63.
  function automatic logic [5:0] last_index(input logic [5:0] count);
    return (count == 6'd0) ? 6'd0 : count - 6'd1;
  endfunction

endpackage

// File: rtl/conv_sched_param_fifo.sv
// sched_param_fifo: synchronous FIFO that holds bias+weight words until the
// scheduler fetches them for a kernel pass.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   push, wdata  write request and data (dropped when full unless a pop occurs in the same cycle)
//   pop, rdata   read request; rdata always shows the head entry
//   flush        discards all entries; wins over a same-cycle push or pop
//   full, empty  occupancy flags
module sched_param_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop frees the head slot in the same cycle, so a push into a full
  // FIFO is still accepted when it is paired with a pop.
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/conv_sched.sv
// conv_sched: sequences the conv datapath for one layer.
// The command word arrives from the AXI-Lite config block and is registered once
// before the FSM decodes it. START therefore reaches the FSM one cycle after it is
// presented, and the same applies to ABORT.
// Each kernel pass runs FETCH (pop params) -> LOAD (o_kload) -> RUN (wait for i_pass_done) -> NEXT.
// Passes are ordered with oc in the outer loop and ic in the inner loop.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   i_state/i_layer/i_num_ic/i_num_oc/i_valid   command word
//   i_params, i_params_valid              bias+weight pushes into the param FIFO
//   i_pass_done                           PE/DMA finished the current pass
//   o_kload, o_bias, o_weights            kernel load pulse and held kernel data
//   o_pass_start, o_first_ic, o_last_ic   pass control towards the PE array
//   o_layer, o_ic, o_oc                   current indices
//   o_busy, o_done, o_err                 status
// Optional feature: define SCHED_PERF_EN to add o_busy_cycles, a saturating busy-cycle counter.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int PARAM_DEPTH = 4,
  parameter int PARAM_W     = 80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         i_state,
  input  logic [1:0]         i_layer,
  input  logic [5:0]         i_num_ic,
  input  logic [5:0]         i_num_oc,
  input  logic               i_valid,
  input  logic [PARAM_W-1:0] i_params,
  input  logic               i_params_valid,
  input  logic               i_pass_done,
  output logic               o_kload,
  output logic [7:0]         o_bias,
  output logic [WGT_W-1:0]   o_weights,
  output logic               o_pass_start,
  output logic               o_first_ic,
  output logic               o_last_ic,
  output logic [1:0]         o_layer,
  output logic [5:0]         o_ic,
  output logic [5:0]         o_oc,
  output logic               o_busy,
  output logic               o_done,
  output logic [1:0]         o_err
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]        o_busy_cycles
`endif
);

  sched_state_e state;
  sched_state_e next_state;

  logic         cmd_valid;
  logic [1:0]   cmd_code;
  logic [1:0]   cmd_layer;
  logic [5:0]   cmd_num_ic;
  logic [5:0]   cmd_num_oc;
  logic         start_cmd;
  logic         abort_cmd;

  logic         start_accept;
  logic         start_busy;
  logic         fifo_pop;
  logic         fifo_flush;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_overflow;
  logic [PARAM_W-1:0] fifo_rdata;

  logic [5:0]   ic_last;
  logic [5:0]   oc_last;
  logic         in_pass;
  logic [1:0]   err_next;

  // Command register: isolates the FSM from the config block timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= CMD_NOP;
      cmd_layer  <= '0;
      cmd_num_ic <= '0;
      cmd_num_oc <= '0;
    end else begin
      cmd_valid  <= i_valid;
      cmd_code   <= i_state;
      cmd_layer  <= i_layer;
      cmd_num_ic <= i_num_ic;
      cmd_num_oc <= i_num_oc;
    end
  end

  assign start_cmd = cmd_valid && (cmd_code == CMD_START);
  assign abort_cmd = cmd_valid && (cmd_code == CMD_ABORT);

  sched_param_fifo #(
    .DEPTH (PARAM_DEPTH),
    .WIDTH (PARAM_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (i_params_valid),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (i_params),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A push is lost only when the FIFO is full with no pop to make room.
  // A push during a flush is discarded by the flush, not counted as an overflow.
  assign fifo_overflow = i_params_valid && fifo_full && !fifo_pop && !fifo_flush;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Abort is handled before the per-state logic. This gives it priority over
  // i_pass_done in RUN and prevents a pop during FETCH in the same cycle.
  always_comb begin
    next_state   = state;
    start_accept = 1'b0;
    start_busy   = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    if (state == ST_IDLE) begin
      if (start_cmd) begin
        start_accept = 1'b1;
        if (cmd_num_ic == 6'd0 || cmd_num_oc == 6'd0) next_state = ST_DONE;
        else                                          next_state = ST_FETCH;
      end
    end else if (abort_cmd) begin
      fifo_flush = 1'b1;
      next_state = ST_IDLE;
    end else begin
      start_busy = start_cmd;
      case (state)
        ST_FETCH: begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            next_state = ST_LOAD;
          end
        end
        ST_LOAD: next_state = ST_RUN;
        ST_RUN: begin
          if (i_pass_done) next_state = ST_NEXT;
        end
        ST_NEXT: begin
          if (o_ic < ic_last || o_oc < oc_last) next_state = ST_FETCH;
          else                                  next_state = ST_DONE;
        end
        ST_DONE: next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Layer configuration and pass indices. ic and oc advance only while leaving NEXT.
  // After the last pass, ic has wrapped to 0 and oc holds the last index.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_layer <= '0;
      ic_last <= '0;
      oc_last <= '0;
      o_ic    <= '0;
      o_oc    <= '0;
    end else if (start_accept) begin
      o_layer <= cmd_layer;
      ic_last <= last_index(cmd_num_ic);
      oc_last <= last_index(cmd_num_oc);
      o_ic    <= '0;
      o_oc    <= '0;
    end else if (state == ST_NEXT && !abort_cmd) begin
      if (o_ic < ic_last) begin
        o_ic <= o_ic + 6'd1;
      end else begin
        o_ic <= '0;
        if (o_oc < oc_last) o_oc <= o_oc + 6'd1;
      end
    end
  end

  // The kernel registers capture the FIFO head when it is popped.
  // They hold through LOAD and RUN until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_bias    <= '0;
      o_weights <= '0;
    end else if (fifo_pop) begin
      o_bias    <= fifo_rdata[BIAS_MSB:BIAS_LSB];
      o_weights <= fifo_rdata[WGT_W-1:0];
    end
  end

  // RUN is entered only from LOAD, so a flag registered on that transition
  // marks the first RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) o_pass_start <= 1'b0;
    else     o_pass_start <= (state == ST_LOAD) && (next_state == ST_RUN);
  end

  // An accepted START clears the error bits. An event in the same cycle
  // still sets its bit.
  always_comb begin
    err_next = start_accept ? 2'b00 : o_err;
    if (fifo_overflow) err_next[ERR_OVF]  = 1'b1;
    if (start_busy)    err_next[ERR_BUSY] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) o_err <= '0;
    else     o_err <= err_next;
  end

  // The pass flags hold for every state that belongs to a pass,
  // so the PE array sees them stable across LOAD and RUN.
  assign in_pass    = (state == ST_FETCH) || (state == ST_LOAD) ||
                      (state == ST_RUN)   || (state == ST_NEXT);
  assign o_first_ic = in_pass && (o_ic == 6'd0);
  assign o_last_ic  = in_pass && (o_ic == ic_last);
  assign o_kload    = (state == ST_LOAD);
  assign o_done     = (state == ST_DONE);
  assign o_busy     = (state != ST_IDLE);

`ifdef SCHED_PERF_EN
  // The counter restarts when a layer is accepted and freezes once the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst)                                      o_busy_cycles <= '0;
    else if (start_accept)                        o_busy_cycles <= '0;
    else if (o_busy && o_busy_cycles != '1)       o_busy_cycles <= o_busy_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Testbench for conv_sched.
// The stimulus process queues the expected kernel loads and layer completions.
// A separate monitor pops those queues whenever the DUT pulses o_kload or o_done.
module tb_conv_sched;

  logic         clk;
  logic         rst;
  logic [1:0]   i_state;
  logic [1:0]   i_layer;
  logic [5:0]   i_num_ic;
  logic [5:0]   i_num_oc;
  logic         i_valid;
  logic [79:0]  i_params;
  logic         i_params_valid;
  logic         i_pass_done;
  logic         o_kload;
  logic [7:0]   o_bias;
  logic [71:0]  o_weights;
  logic         o_pass_start;
  logic         o_first_ic;
  logic         o_last_ic;
  logic [1:0]   o_layer;
  logic [5:0]   o_ic;
  logic [5:0]   o_oc;
  logic         o_busy;
  logic         o_done;
  logic [1:0]   o_err;
`ifdef SCHED_PERF_EN
  logic [31:0]  o_busy_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  logic [95:0] kq [$];
  logic [13:0] dq [$];

  conv_sched dut (
    .clk            (clk),
    .rst            (rst),
    .i_state        (i_state),
    .i_layer        (i_layer),
    .i_num_ic       (i_num_ic),
    .i_num_oc       (i_num_oc),
    .i_valid        (i_valid),
    .i_params       (i_params),
    .i_params_valid (i_params_valid),
    .i_pass_done    (i_pass_done),
    .o_kload        (o_kload),
    .o_bias         (o_bias),
    .o_weights      (o_weights),
    .o_pass_start   (o_pass_start),
    .o_first_ic     (o_first_ic),
    .o_last_ic      (o_last_ic),
    .o_layer        (o_layer),
    .o_ic           (o_ic),
    .o_oc           (o_oc),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
`ifdef SCHED_PERF_EN
    ,
    .o_busy_cycles  (o_busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Parameter word k: bias = A0+k, weight j = k*16+j
  function automatic logic [79:0] mkParam(input int k);
    logic [79:0] p;
    p[79:72] = 8'(8'hA0 + k);
    for (int j = 0; j < 9; j++) p[j*8 +: 8] = 8'(k*16 + j);
    return p;
  endfunction

  function automatic logic [95:0] kExp(input int k, input logic first, input logic last,
                                       input logic [1:0] layer, input logic [5:0] ic,
                                       input logic [5:0] oc);
    return {mkParam(k), first, last, layer, ic, oc};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] code, input logic [1:0] layer,
                               input logic [5:0] nic, input logic [5:0] noc);
    i_state  = code;
    i_layer  = layer;
    i_num_ic = nic;
    i_num_oc = noc;
    i_valid  = 1'b1;
    tick(1);
    i_valid  = 1'b0;
    i_state  = 2'd0;
  endtask

  task automatic pushParam(input int k);
    i_params       = mkParam(k);
    i_params_valid = 1'b1;
    tick(1);
    i_params_valid = 1'b0;
  endtask

  task automatic passDone();
    i_pass_done = 1'b1;
    tick(1);
    i_pass_done = 1'b0;
  endtask

  task automatic waitPassStart(input string name, output int n);
    n = 0;
    while (!o_pass_start && n < 40) begin
      tick(1);
      n++;
    end
    checkOutput(name, 128'(o_pass_start), 128'd1);
  endtask

  function automatic logic [127:0] allOutputs();
    return 128'({o_kload, o_bias, o_weights, o_pass_start, o_first_ic, o_last_ic,
                 o_layer, o_ic, o_oc, o_busy, o_done, o_err});
  endfunction

  // Monitor: each output event must match the next queued expectation
  initial begin
    logic [95:0] ke;
    logic [13:0] de;
    forever begin
      @(negedge clk);
      if (!rst && o_kload) begin
        if (kq.size() == 0) begin
          checkOutput("kload_unexpected", 128'd1, 128'd0);
        end else begin
          ke = kq.pop_front();
          checkOutput("kload", 128'({o_bias, o_weights, o_first_ic, o_last_ic, o_layer, o_ic, o_oc}),
                      128'(ke));
        end
      end
      if (!rst && o_done) begin
        if (dq.size() == 0) begin
          checkOutput("done_unexpected", 128'd1, 128'd0);
        end else begin
          de = dq.pop_front();
          checkOutput("done", 128'({o_layer, o_ic, o_oc}), 128'(de));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    i_state = 2'd0; i_layer = 2'd0; i_num_ic = 6'd0; i_num_oc = 6'd0; i_valid = 1'b0;
    i_params = '0; i_params_valid = 1'b0; i_pass_done = 1'b0;
    tick(3);
    rst = 1'b0;
    checkOutput("reset_outputs", allOutputs(), 128'd0);

    // Test 1: 2x2 layer over four prefetched kernels
    $display("[TB] test 1: 2x2 layer");
    for (int k = 0; k < 4; k++) pushParam(k);
    kq.push_back(kExp(0, 1'b1, 1'b0, 2'd2, 6'd0, 6'd0));
    kq.push_back(kExp(1, 1'b0, 1'b1, 2'd2, 6'd1, 6'd0));
    kq.push_back(kExp(2, 1'b1, 1'b0, 2'd2, 6'd0, 6'd1));
    kq.push_back(kExp(3, 1'b0, 1'b1, 2'd2, 6'd1, 6'd1));
    dq.push_back({2'd2, 6'd0, 6'd1});
    applyStimulus(2'd1, 2'd2, 6'd2, 6'd2);
    tick(1);
    checkOutput("t1_kload_early", 128'(o_kload), 128'd0);
    tick(1);
    checkOutput("t1_kload_latency", 128'(o_kload), 128'd1);
    for (int k = 0; k < 4; k++) begin
      waitPassStart($sformatf("t1_pass%0d", k), n);
      checkOutput($sformatf("t1_start_latency%0d", k), 128'(n), (k == 0) ? 128'd1 : 128'd3);
      passDone();
    end
    tick(2);
    checkOutput("t1_idle_state", 128'({o_busy, o_layer, o_ic, o_oc, o_err}),
                128'({1'b0, 2'd2, 6'd0, 6'd1, 2'b00}));

    // Test 2: FETCH stalls until a kernel arrives
    $display("[TB] test 2: empty FIFO stall");
    dq.push_back({2'd3, 6'd0, 6'd0});
    applyStimulus(2'd1, 2'd3, 6'd1, 6'd1);
    tick(10);
    checkOutput("t2_stall", 128'({o_busy, o_kload, o_pass_start}), 128'({1'b1, 1'b0, 1'b0}));
    kq.push_back(kExp(4, 1'b1, 1'b1, 2'd3, 6'd0, 6'd0));
    pushParam(4);
    tick(1);
    checkOutput("t2_kload_after_pop", 128'(o_kload), 128'd1);
    waitPassStart("t2_pass", n);
    passDone();
    tick(2);

    // Test 3: fifth push into a full FIFO is dropped
    $display("[TB] test 3: FIFO overflow");
    for (int k = 5; k < 10; k++) pushParam(k);
    checkOutput("t3_err_ovf", 128'(o_err), 128'd1);
    for (int k = 0; k < 4; k++) kq.push_back(kExp(5 + k, 1'b1, 1'b1, 2'd1, 6'd0, 6'(k)));
    dq.push_back({2'd1, 6'd0, 6'd3});
    applyStimulus(2'd1, 2'd1, 6'd1, 6'd4);
    tick(1);
    checkOutput("t3_err_cleared", 128'(o_err), 128'd0);
    for (int k = 0; k < 4; k++) begin
      waitPassStart($sformatf("t3_pass%0d", k), n);
      passDone();
    end
    tick(2);

    // Test 4: abort reaches the FSM in the same cycle as pass_done
    $display("[TB] test 4: abort during RUN");
    pushParam(10);
    pushParam(11);
    kq.push_back(kExp(10, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0));
    applyStimulus(2'd1, 2'd0, 6'd2, 6'd1);
    waitPassStart("t4_pass", n);
    i_state = 2'd2;
    i_valid = 1'b1;
    tick(1);
    i_valid = 1'b0;
    i_state = 2'd0;
    passDone();
    checkOutput("t4_abort_idle", 128'({o_busy, o_first_ic, o_last_ic}), 128'd0);
    applyStimulus(2'd1, 2'd0, 6'd1, 6'd1);
    tick(6);
    checkOutput("t4_fifo_flushed", 128'({o_busy, o_kload}), 128'({1'b1, 1'b0}));
    applyStimulus(2'd2, 2'd0, 6'd0, 6'd0);
    tick(1);
    checkOutput("t4_abort_fetch", 128'(o_busy), 128'd0);

    // Test 5: zero channel count, then START while busy
    $display("[TB] test 5: zero count and busy START");
    dq.push_back({2'd1, 6'd0, 6'd0});
    applyStimulus(2'd1, 2'd1, 6'd0, 6'd3);
    tick(1);
    checkOutput("t5_done_latency", 128'({o_done, o_kload}), 128'({1'b1, 1'b0}));
    tick(1);
    checkOutput("t5_idle", 128'(o_busy), 128'd0);
`ifdef SCHED_PERF_EN
    checkOutput("t5_busy_cycles", 128'(o_busy_cycles), 128'd1);
`endif
    pushParam(12);
    kq.push_back(kExp(12, 1'b1, 1'b1, 2'd0, 6'd0, 6'd0));
    dq.push_back({2'd0, 6'd0, 6'd0});
    applyStimulus(2'd1, 2'd0, 6'd1, 6'd1);
    waitPassStart("t5_pass", n);
    applyStimulus(2'd1, 2'd3, 6'd5, 6'd5);
    tick(1);
    checkOutput("t5_err_busy", 128'({o_err, o_busy, o_layer}), 128'({2'b10, 1'b1, 2'd0}));
    passDone();
    tick(2);
    checkOutput("t5_err_sticky", 128'({o_err, o_busy}), 128'({2'b10, 1'b0}));

    // Test 6: reset during RUN
    $display("[TB] test 6: reset during RUN");
    pushParam(13);
    kq.push_back(kExp(13, 1'b1, 1'b1, 2'd2, 6'd0, 6'd0));
    applyStimulus(2'd1, 2'd2, 6'd1, 6'd1);
    waitPassStart("t6_pass", n);
    rst = 1'b1;
    tick(1);
    checkOutput("t6_reset_outputs", allOutputs(), 128'd0);
`ifdef SCHED_PERF_EN
    checkOutput("t6_busy_cycles", 128'(o_busy_cycles), 128'd0);
`endif
    rst = 1'b0;
    tick(3);

    checkOutput("kload_queue_drained", 128'(kq.size()), 128'd0);
    checkOutput("done_queue_drained", 128'(dq.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
